// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, with word-mode (W) variants and a valid/ready/done handshake.
module muldiv_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic             word_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t r_state, w_next;

    logic [2:0]         r_op;
    logic               r_word;
    logic               r_sign_a, r_sign_b;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;

    function automatic logic [WIDTH-1:0] sext_half(input logic [WIDTH-1:0] v);
        return {{H{v[H-1]}}, v[H-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] zext_half(input logic [WIDTH-1:0] v);
        return {{H{1'b0}}, v[H-1:0]};
    endfunction

    // Issue-side decode and operand conditioning
    logic             w_div_signed, w_sgn_a_op, w_sgn_b_op;
    logic [WIDTH-1:0] w_a_ext, w_b_ext, w_mag_a, w_mag_b;
    logic             w_sign_a, w_sign_b;
    logic             w_b_zero, w_a_min, w_b_neg1, w_ovf, w_special, w_accept;
    logic [WIDTH-1:0] w_spec_raw, w_spec_res;

    // Word-mode multiplies only need the low N product bits, so they run unsigned.
    assign w_div_signed = op_i[2] & ~op_i[0];
    assign w_sgn_a_op   = w_div_signed | (~op_i[2] & ~word_i & (op_i[1] ^ op_i[0]));
    assign w_sgn_b_op   = w_div_signed | (~op_i[2] & ~word_i & (op_i[1:0] == 2'b01));

    always_comb begin
        w_a_ext = a_i;
        w_b_ext = b_i;
        if (word_i) begin
            w_a_ext = w_div_signed ? sext_half(a_i) : zext_half(a_i);
            w_b_ext = w_div_signed ? sext_half(b_i) : zext_half(b_i);
        end
    end

    assign w_sign_a = w_sgn_a_op & w_a_ext[WIDTH-1];
    assign w_sign_b = w_sgn_b_op & w_b_ext[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -w_a_ext : w_a_ext;
    assign w_mag_b  = w_sign_b ? -w_b_ext : w_b_ext;

    assign w_b_zero  = (w_b_ext == '0);
    assign w_a_min   = word_i ? (a_i[H-1:0] == {1'b1, {(H-1){1'b0}}})
                              : (a_i == {1'b1, {(WIDTH-1){1'b0}}});
    assign w_b_neg1  = word_i ? (&b_i[H-1:0]) : (&b_i);
    assign w_ovf     = w_div_signed & w_a_min & w_b_neg1;
    assign w_special = op_i[2] & (w_b_zero | w_ovf);
    assign w_accept  = valid_i & (r_state == S_IDLE) & ~flush_i;

    always_comb begin
        w_spec_raw = '0;
        if (w_b_zero)
            w_spec_raw = op_i[1] ? w_a_ext : '1;
        else
            w_spec_raw = op_i[1] ? '0 : w_a_ext;
        w_spec_res = word_i ? sext_half(w_spec_raw) : w_spec_raw;
    end

    // Iteration step: both algorithms consume operand bits MSB-first
    logic               w_abit, w_bbit, w_qbit;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next;
    logic [WIDTH:0]     w_shift, w_diff;
    logic [WIDTH-1:0]   w_rem_next;

    assign w_bbit     = r_word ? r_b[H-1] : r_b[WIDTH-1];
    assign w_abit     = r_word ? r_a[H-1] : r_a[WIDTH-1];
    assign w_mul_next = {r_acc[2*WIDTH-2:0], 1'b0} + (w_bbit ? {{WIDTH{1'b0}}, r_a} : '0);
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], w_abit};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_qbit};

    // Sign fix-up and result selection
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_sel, w_fix_res;

    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_sel = w_prod[WIDTH-1:0];
        case (r_op)
            3'b001, 3'b010, 3'b011: w_sel = r_word ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_sel = w_quo;
            3'b110, 3'b111:         w_sel = w_rem;
            default:                w_sel = w_prod[WIDTH-1:0];
        endcase
        w_fix_res = r_word ? sext_half(w_sel) : w_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (flush_i)                 w_next = S_IDLE;
                else if (r_cnt == CW'(1))    w_next = S_FIX;
            end
            S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= '0;
            r_word   <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op     <= op_i;
                    r_word   <= word_i;
                    r_sign_a <= w_sign_a;
                    r_sign_b <= w_sign_b;
                    r_a      <= w_mag_a;
                    r_b      <= w_mag_b;
                    r_acc    <= '0;
                    if (w_special) begin
                        r_cnt    <= '0;
                        r_result <= w_spec_res;
                    end else begin
                        r_cnt <= word_i ? CW'(H) : CW'(WIDTH);
                    end
                end
                S_BUSY: if (!flush_i) begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_op[2]) begin
                        r_acc <= w_div_next;
                        r_a   <= r_a << 1;
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= r_b << 1;
                    end
                end
                S_FIX: if (!flush_i) r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    // A flush in DONE must still suppress the pulse, hence the combinational gate.
    assign ready_o  = (r_state == S_IDLE);
    assign done_o   = (r_state == S_DONE) & ~flush_i;
    assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized vectors checked
// against a behavioural model, and hand-written flush/reset sequences.
module tb_muldiv_unit;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [2:0]    op_i = '0;
    logic          word_i = 1'b0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          flush_i = 1'b0;
    logic          done_o;
    logic [W-1:0]  result_o;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .word_i   (word_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        tbl[18];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_exp = '0;

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  a32, b32, r32;
        logic [63:0]  r;
        r = '0;
        if (!word) begin
            case (op)
                3'd0: r = a * b;
                3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
                3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
                3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
                3'd4: begin
                    if (b == 0) r = '1;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                    else r = $signed(a) / $signed(b);
                end
                3'd5: begin if (b == 0) r = '1; else r = a / b; end
                3'd6: begin
                    if (b == 0) r = a;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                    else r = $signed(a) % $signed(b);
                end
                default: begin if (b == 0) r = a; else r = a % b; end
            endcase
        end else begin
            a32 = a[31:0];
            b32 = b[31:0];
            r32 = '0;
            case (op)
                3'd4: begin
                    if (b32 == 0) r32 = '1;
                    else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                    else r32 = $signed(a32) / $signed(b32);
                end
                3'd5: begin if (b32 == 0) r32 = '1; else r32 = a32 / b32; end
                3'd6: begin
                    if (b32 == 0) r32 = a32;
                    else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                    else r32 = $signed(a32) % $signed(b32);
                end
                3'd7: begin if (b32 == 0) r32 = a32; else r32 = a32 % b32; end
                default: r32 = a32 * b32;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
        logic bz, ovf;
        if (word) begin
            bz  = (b[31:0] == 0);
            ovf = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        end else begin
            bz  = (b == 0);
            ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
        end
        if (op[2] && (bz || (!op[0] && ovf))) return 1;
        return word ? 34 : 66;
    endfunction

    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        int k = 0;
        while (!ready_o && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk64("issue_ready", {63'd0, ready_o}, 64'd1);
        valid_i = 1'b1;
        op_i    = op;
        word_i  = w;
        a_i     = a;
        b_i     = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        op_i    = 3'($urandom_range(0, 7));
        word_i  = 1'($urandom_range(0, 1));
        a_i     = {$urandom, $urandom};
        b_i     = {$urandom, $urandom};
    endtask

    task automatic wait_done(input string nm);
        int   k = 0;
        exp_t e;
        while (!done_o && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue required one entry", nm);
        end else begin
            e = sb_q.pop_front();
            chk64({nm, "_done"}, {63'd0, done_o}, 64'd1);
            chk64({nm, "_result"}, result_o, e.res);
            chk_int({nm, "_latency"}, k + 1, e.lat);
            last_exp = e.res;
        end
        @(posedge clk); #1;
        chk64({nm, "_single_pulse"}, {63'd0, done_o}, 64'd0);
        chk64({nm, "_ready_after"}, {63'd0, ready_o}, 64'd1);
    endtask

    task automatic run_vec(input string nm, input logic [2:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int lat);
        exp_t e;
        e.res = exp;
        e.lat = lat;
        issue(op, w, a, b);
        sb_q.push_back(e);
        wait_done(nm);
    endtask

    task automatic watch_no_done(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done_o) seen++;
            @(posedge clk); #1;
        end
        chk_int({nm, "_no_done"}, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;

        tbl[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        tbl[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        tbl[2]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66};
        tbl[3]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        tbl[4]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        tbl[5]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        tbl[6]  = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66};
        tbl[7]  = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66};
        tbl[8]  = '{3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        tbl[9]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        tbl[10] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        tbl[11] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        tbl[12] = '{3'd5, 1'b1, 64'h0000_0001_0000_0010, 64'd2, 64'd8, 34};
        tbl[13] = '{3'd0, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 34};
        tbl[14] = '{3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        tbl[15] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        tbl[16] = '{3'd1, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 34};
        tbl[17] = '{3'd7, 1'b1, 64'h1234_0000_8000_0005, 64'h5678_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, 1};

        repeat (3) @(posedge clk);
        #1;
        chk64("reset_ready", {63'd0, ready_o}, 64'd1);
        chk64("reset_done", {63'd0, done_o}, 64'd0);
        chk64("reset_result", result_o, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++)
            run_vec($sformatf("vec%0d", i), tbl[i].op, tbl[i].word, tbl[i].a, tbl[i].b,
                    tbl[i].exp, tbl[i].lat);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
            case ($urandom_range(0, 3))
                0: b = 64'($urandom_range(1, 20));
                1: b = {$urandom, $urandom};
                2: b = w ? {$urandom, 32'd0} : 64'd0;
                default: b = '1;
            endcase
            run_vec($sformatf("rnd%0d", i), op, w, a, b, ref_model(op, w, a, b),
                    ref_latency(op, w, a, b));
        end

        // Flush in BUSY at cycle t+10
        issue(3'd0, 1'b0, 64'd3, 64'd5);
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk64("flush_ready", {63'd0, ready_o}, 64'd1);
        watch_no_done("flush_busy", 80);
        chk64("flush_result_held", result_o, last_exp);

        // valid together with flush in IDLE must not be accepted
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 3'd0;
        word_i  = 1'b0;
        a_i     = 64'd2;
        b_i     = 64'd3;
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk64("flush_idle_ready", {63'd0, ready_o}, 64'd1);
        watch_no_done("flush_idle", 70);

        run_vec("after_flush_mul", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 66);

        // Asynchronous reset in the middle of BUSY
        issue(3'd5, 1'b0, 64'd100, 64'd7);
        repeat (5) @(posedge clk);
        #1;
        chk64("busy_before_reset", {63'd0, ready_o}, 64'd0);
        reset = 1'b0;
        #1;
        chk64("midreset_ready", {63'd0, ready_o}, 64'd1);
        chk64("midreset_done", {63'd0, done_o}, 64'd0);
        chk64("midreset_result", result_o, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_vec("after_reset_divu", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
